// File: rtl/interrupt_controller.sv
// Interrupt requester for the PC's IRQ/XAddr interface: synchronises, edge-detects,
// masks and prioritises external lines, then issues a one-cycle IRQ with vector and return address.
module interrupt_controller #(
  parameter int          NUM_SRC    = 8,
  parameter logic [31:0] VEC_BASE   = 32'h8000_0008,
  parameter logic [31:0] VEC_STRIDE = 32'd4
) (
  input  logic               clk,
  input  logic               RESET_N,
  input  logic [NUM_SRC-1:0] IRQ_IN,
  input  logic               PC_MSB,
  input  logic [31:0]        PcIncr,
  input  logic               STALL,
  input  logic               MASK_WE,
  input  logic [NUM_SRC-1:0] MASK_WDATA,
  output logic               IRQ,
  output logic [31:0]        XAddr,
  output logic [31:0]        XP,
  output logic [4:0]         CAUSE,
  output logic               IN_SERVICE,
  output logic [NUM_SRC-1:0] PENDING
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TAKE    = 2'd1,
    HANDLER = 2'd2
  } state_t;

  logic [NUM_SRC-1:0] sync1_q, sync2_q, edge_q;
  logic [NUM_SRC-1:0] mask_q;
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] rise, eligible, clr;
  logic [4:0]         sel_idx;
  logic               sel_valid;
  logic               accept;

  state_t      state_q;
  logic        irq_q;
  logic [31:0] xaddr_q;
  logic [31:0] xp_q;
  logic [4:0]  cause_q;
  logic        in_service_q;

  // Per-line 2-FF synchroniser plus a delay flop for rising-edge detection.
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_sync
      always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
          sync1_q[gi] <= 1'b0;
          sync2_q[gi] <= 1'b0;
          edge_q[gi]  <= 1'b0;
        end else begin
          sync1_q[gi] <= IRQ_IN[gi];
          sync2_q[gi] <= sync1_q[gi];
          edge_q[gi]  <= sync2_q[gi];
        end
      end
      assign rise[gi] = sync2_q[gi] & ~edge_q[gi];
    end
  endgenerate

  assign eligible = pending_q & mask_q;

  // Fixed priority: scan downwards so the lowest set index is the last one written.
  always_comb begin
    sel_idx   = 5'd0;
    sel_valid = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        sel_idx   = 5'(i);
        sel_valid = 1'b1;
      end
    end
  end

  assign accept = (state_q == IDLE) && !PC_MSB && !STALL && sel_valid;

  always_comb begin
    clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      clr[i] = accept && (sel_idx == 5'(i));
    end
  end

  // A fresh edge in the acceptance cycle re-arms the source rather than being lost.
  assign pending_d = (pending_q & ~clr) | rise;

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      pending_q <= '0;
      mask_q    <= '0;
    end else begin
      pending_q <= pending_d;
      if (MASK_WE) mask_q <= MASK_WDATA;
    end
  end

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= IDLE;
      irq_q        <= 1'b0;
      xaddr_q      <= VEC_BASE;
      xp_q         <= 32'd0;
      cause_q      <= 5'd0;
      in_service_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q      <= TAKE;
            irq_q        <= 1'b1;
            xaddr_q      <= VEC_BASE + 32'(sel_idx) * VEC_STRIDE;
            cause_q      <= sel_idx;
            in_service_q <= 1'b1;
          end
        end
        TAKE: begin
          xp_q    <= PcIncr;
          irq_q   <= 1'b0;
          state_q <= HANDLER;
        end
        HANDLER: begin
          if (!PC_MSB) begin
            state_q      <= IDLE;
            in_service_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          irq_q        <= 1'b0;
          in_service_q <= 1'b0;
        end
      endcase
    end
  end

  assign IRQ        = irq_q;
  assign XAddr      = xaddr_q;
  assign XP         = xp_q;
  assign CAUSE      = cause_q;
  assign IN_SERVICE = in_service_q;
  assign PENDING    = pending_q;

endmodule
